// File: rtl/fifo_wptr_full.sv
// Write-side pointer and full-flag logic of an asynchronous FIFO: binary/Gray write
// pointer, read-pointer synchronizer, registered full and overflow flags, occupancy estimate.
module fifo_wptr_full #(
   parameter int ADDRWIDTH   = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_en,
   input  logic [ADDRWIDTH:0]   rptr_gray_in,
   output logic [ADDRWIDTH-1:0] waddr,
   output logic                 wr_accept,
   output logic [ADDRWIDTH:0]   wptr_gray,
   output logic                 full,
   output logic                 overflow,
   output logic [ADDRWIDTH:0]   wr_count
);

   localparam int PW = ADDRWIDTH + 1;
   // Full when the next write pointer equals the read pointer with its top two Gray bits inverted.
   localparam logic [PW-1:0] FULL_MASK = PW'(3) << (ADDRWIDTH - 1);
   localparam logic [PW-1:0] DEPTH     = PW'(1) << ADDRWIDTH;

   logic [PW-1:0] wptr_bin_reg;
   logic [PW-1:0] wptr_gray_reg;
   logic          full_reg;
   logic          overflow_reg;
   logic [PW-1:0] sync_reg [SYNC_STAGES];

   logic [PW-1:0] wnext_bin;
   logic [PW-1:0] wnext_gray;
   logic          full_next;
   logic          overflow_next;
   logic [PW-1:0] rptr_gray_sync;
   logic [PW-1:0] rptr_bin_sync;

   assign rptr_gray_sync = sync_reg[SYNC_STAGES-1];

   genvar gi;
   generate
      for (gi = 0; gi < PW; gi++) begin : g_gray2bin
         assign rptr_bin_sync[gi] = ^rptr_gray_sync[PW-1:gi];
      end
   endgenerate

   assign wr_accept     = wr_en & ~full_reg;
   assign wnext_bin     = wptr_bin_reg + PW'(wr_accept);
   assign wnext_gray    = wnext_bin ^ (wnext_bin >> 1);
   assign full_next     = (wnext_gray == (rptr_gray_sync ^ FULL_MASK));
   assign overflow_next = wr_en & full_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_bin_reg  <= '0;
         wptr_gray_reg <= '0;
         full_reg      <= 1'b0;
         overflow_reg  <= 1'b0;
         for (int i = 0; i < SYNC_STAGES; i++) sync_reg[i] <= '0;
      end else begin
         wptr_bin_reg  <= wnext_bin;
         wptr_gray_reg <= wnext_gray;
         full_reg      <= full_next;
         overflow_reg  <= overflow_next;
         sync_reg[0]   <= rptr_gray_in;
         for (int i = 1; i < SYNC_STAGES; i++) sync_reg[i] <= sync_reg[i-1];
      end
   end

   assign waddr     = wptr_bin_reg[ADDRWIDTH-1:0];
   assign wptr_gray = wptr_gray_reg;
   assign full      = full_reg;
   assign overflow  = overflow_reg;
   // full can stay set one edge after the synchronized read pointer moves; report a full FIFO then.
   assign wr_count  = full_reg ? DEPTH : (wptr_bin_reg - rptr_bin_sync);

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed bench for fifo_wptr_full (ADDRWIDTH=2, SYNC_STAGES=2); stimulus queues
// hand-computed per-cycle expectations, a negedge monitor pops and compares them.
module tb_fifo_wptr_full;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_en = 1'b0;
   logic [2:0] rptr_gray_in = 3'b000;
   logic [1:0] waddr;
   logic       wr_accept;
   logic [2:0] wptr_gray;
   logic       full;
   logic       overflow;
   logic [2:0] wr_count;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      string      name;
      logic       acc;
      logic [1:0] waddr;
      logic [2:0] wg;
      logic       full;
      logic       ovf;
      logic [2:0] cnt;
   } exp_t;

   exp_t sb_q[$];

   fifo_wptr_full #(.ADDRWIDTH(2), .SYNC_STAGES(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .rptr_gray_in(rptr_gray_in),
      .waddr       (waddr),
      .wr_accept   (wr_accept),
      .wptr_gray   (wptr_gray),
      .full        (full),
      .overflow    (overflow),
      .wr_count    (wr_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string txn, input string tag, input logic [2:0] act, input logic [2:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s.%s actual=%b required=%b", txn, tag, act, exp);
      end
   endtask

   // Monitor: outputs are presented once per cycle; compare away from the rising edge.
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         $display("txn %-6s acc=%b waddr=%0d wg=%b full=%b ovf=%b cnt=%0d", e.name,
                  wr_accept, waddr, wptr_gray, full, overflow, wr_count);
         check(e.name, "wr_accept", {2'b00, wr_accept}, {2'b00, e.acc});
         check(e.name, "waddr",     {1'b0, waddr},      {1'b0, e.waddr});
         check(e.name, "wptr_gray", wptr_gray,          e.wg);
         check(e.name, "full",      {2'b00, full},      {2'b00, e.full});
         check(e.name, "overflow",  {2'b00, overflow},  {2'b00, e.ovf});
         check(e.name, "wr_count",  wr_count,           e.cnt);
      end
   end

   // One row per cycle: inputs for this cycle, outputs expected during this cycle.
   task automatic cyc(input string nm, input logic r_st, input logic w, input logic [2:0] rp,
                      input logic ea, input logic [1:0] ew, input logic [2:0] eg,
                      input logic ef, input logic eo, input logic [2:0] ec);
      exp_t e;
      @(posedge clk);
      #1;
      rst = r_st;
      wr_en = w;
      rptr_gray_in = rp;
      e.name = nm; e.acc = ea; e.waddr = ew; e.wg = eg; e.full = ef; e.ovf = eo; e.cnt = ec;
      sb_q.push_back(e);
   endtask

   initial begin
      //   name    rst wr  rptr    acc waddr wg      full ovf cnt
      cyc("rst0",  1, 0, 3'b000, 0, 2'd0, 3'b000, 0, 0, 3'd0);
      // fill with read pointer idle
      cyc("p1",    0, 1, 3'b000, 1, 2'd0, 3'b000, 0, 0, 3'd0);
      cyc("p2",    0, 1, 3'b000, 1, 2'd1, 3'b001, 0, 0, 3'd1);
      cyc("p3",    0, 1, 3'b000, 1, 2'd2, 3'b011, 0, 0, 3'd2);
      cyc("p4",    0, 1, 3'b000, 1, 2'd3, 3'b010, 0, 0, 3'd3);
      // blocked pushes while full, back-to-back overflow
      cyc("ovf1",  0, 1, 3'b000, 0, 2'd0, 3'b110, 1, 0, 3'd4);
      cyc("ovf2",  0, 1, 3'b000, 0, 2'd0, 3'b110, 1, 1, 3'd4);
      cyc("ovf3",  0, 1, 3'b000, 0, 2'd0, 3'b110, 1, 1, 3'd4);
      // read pointer advances; full clears two edges after first sample
      cyc("rd1",   0, 0, 3'b001, 0, 2'd0, 3'b110, 1, 1, 3'd4);
      cyc("lag1",  0, 0, 3'b001, 0, 2'd0, 3'b110, 1, 0, 3'd4);
      cyc("lag2",  0, 0, 3'b001, 0, 2'd0, 3'b110, 1, 0, 3'd4);
      cyc("clr",   0, 0, 3'b110, 0, 2'd0, 3'b110, 0, 0, 3'd3);
      cyc("drn",   0, 0, 3'b110, 0, 2'd0, 3'b110, 0, 0, 3'd3);
      // pushes with reads keeping pace, through the pointer wrap
      cyc("w1",    0, 1, 3'b110, 1, 2'd0, 3'b110, 0, 0, 3'd0);
      cyc("w2",    0, 1, 3'b111, 1, 2'd1, 3'b111, 0, 0, 3'd1);
      cyc("w3",    0, 1, 3'b101, 1, 2'd2, 3'b101, 0, 0, 3'd2);
      cyc("w4",    0, 1, 3'b100, 1, 2'd3, 3'b100, 0, 0, 3'd2);
      cyc("wrap",  0, 0, 3'b000, 0, 2'd0, 3'b000, 0, 0, 3'd2);
      cyc("sy1",   0, 0, 3'b000, 0, 2'd0, 3'b000, 0, 0, 3'd1);
      // fill to three, then push and read in the same cycle
      cyc("q1",    0, 1, 3'b000, 1, 2'd0, 3'b000, 0, 0, 3'd0);
      cyc("q2",    0, 1, 3'b000, 1, 2'd1, 3'b001, 0, 0, 3'd1);
      cyc("q3",    0, 1, 3'b000, 1, 2'd2, 3'b011, 0, 0, 3'd2);
      cyc("same",  0, 1, 3'b001, 1, 2'd3, 3'b010, 0, 0, 3'd3);
      cyc("sf1",   0, 0, 3'b001, 0, 2'd0, 3'b110, 1, 0, 3'd4);
      cyc("sf2",   0, 0, 3'b001, 0, 2'd0, 3'b110, 1, 0, 3'd4);
      // refill, then reset while full with a push pending
      cyc("sfc",   0, 1, 3'b001, 1, 2'd0, 3'b110, 0, 0, 3'd3);
      cyc("rstf",  1, 1, 3'b001, 0, 2'd1, 3'b111, 1, 0, 3'd4);
      cyc("post",  0, 1, 3'b000, 1, 2'd0, 3'b000, 0, 0, 3'd0);
      cyc("post2", 0, 0, 3'b000, 0, 2'd1, 3'b001, 0, 0, 3'd1);

      for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
      #1;
      if (sb_q.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain pending=%0d required=0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
